// File: rtl/rob_commit.sv
// rob_commit: 8-entry reorder buffer with in-order retirement.
// Issue allocates at the tail, execution units complete entries by tag, and
// the oldest completed entry retires one per cycle toward regbank.
//
// Handshake: an allocation fires only on a cycle where alloc_valid && alloc_ready
// are both high at the clock edge; alloc_ready is purely !full (registered
// occupancy), so it never depends on alloc_valid or on same-cycle retirement.
module rob_commit #(
    parameter int ROB_DEPTH = 8,
    parameter int TAG_W     = 3,
    parameter int REG_W     = 4,
    parameter int FUNC_W    = 4,
    parameter int DATA_W    = 16
) (
    input  logic              clk1,
    input  logic              rst_n,
    input  logic              alloc_valid,
    input  logic [FUNC_W-1:0] alloc_func,
    input  logic [REG_W-1:0]  alloc_rd,
    output logic              alloc_ready,
    output logic [TAG_W-1:0]  alloc_tag,
    input  logic              wb_valid,
    input  logic [TAG_W-1:0]  wb_tag,
    input  logic [DATA_W-1:0] wb_data,
    input  logic              flush,
    output logic              commit_valid,
    output logic              commit_we,
    output logic [REG_W-1:0]  commit_rd,
    output logic [DATA_W-1:0] commit_data,
    output logic [TAG_W-1:0]  commit_tag,
    output logic [TAG_W-1:0]  head_p,
    output logic [TAG_W-1:0]  tail_p,
    output logic [TAG_W:0]    count,
    output logic              full,
    output logic              empty,
    output logic              stray_wb
);

    localparam int CNT_W = TAG_W + 1;

    // Per-entry state
    logic              valid_q [ROB_DEPTH];
    logic              valid_d [ROB_DEPTH];
    logic              done_q  [ROB_DEPTH];
    logic              done_d  [ROB_DEPTH];
    logic [FUNC_W-1:0] func_q  [ROB_DEPTH];
    logic [FUNC_W-1:0] func_d  [ROB_DEPTH];
    logic [REG_W-1:0]  rd_q    [ROB_DEPTH];
    logic [REG_W-1:0]  rd_d    [ROB_DEPTH];
    logic [DATA_W-1:0] data_q  [ROB_DEPTH];
    logic [DATA_W-1:0] data_d  [ROB_DEPTH];

    // Pointers and occupancy
    logic [TAG_W-1:0] head_q, head_d;
    logic [TAG_W-1:0] tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;

    // Registered retirement outputs
    logic              commit_valid_q, commit_valid_d;
    logic              commit_we_q, commit_we_d;
    logic [REG_W-1:0]  commit_rd_q, commit_rd_d;
    logic [DATA_W-1:0] commit_data_q, commit_data_d;
    logic [TAG_W-1:0]  commit_tag_q, commit_tag_d;
    logic              stray_q, stray_d;

    logic full_w;
    logic alloc_fire;
    logic wb_hit;
    logic commit_fire;
    logic unused_func_lo;

    // Opcode class only needs the upper two bits; the low bits are carried for completeness.
    assign unused_func_lo = ^func_q[head_q][1:0];

    assign full_w      = (count_q == CNT_W'(ROB_DEPTH));
    assign alloc_fire  = alloc_valid && !full_w;
    // Hit/commit use pre-edge state, so a writeback never retires in the edge it lands.
    assign wb_hit      = wb_valid && valid_q[wb_tag] && !done_q[wb_tag];
    assign commit_fire = valid_q[head_q] && done_q[head_q];

    assign alloc_ready  = !full_w;
    assign alloc_tag    = tail_q;
    assign full         = full_w;
    assign empty        = (count_q == '0);
    assign count        = count_q;
    assign head_p       = head_q;
    assign tail_p       = tail_q;
    assign commit_valid = commit_valid_q;
    assign commit_we    = commit_we_q;
    assign commit_rd    = commit_rd_q;
    assign commit_data  = commit_data_q;
    assign commit_tag   = commit_tag_q;
    assign stray_wb     = stray_q;

    // Next-state: flush wins over everything, else writeback, allocate and retire together.
    always_comb begin
        valid_d        = valid_q;
        done_d         = done_q;
        func_d         = func_q;
        rd_d           = rd_q;
        data_d         = data_q;
        head_d         = head_q;
        tail_d         = tail_q;
        count_d        = count_q;
        commit_valid_d = 1'b0;
        commit_we_d    = commit_we_q;
        commit_rd_d    = commit_rd_q;
        commit_data_d  = commit_data_q;
        commit_tag_d   = commit_tag_q;
        stray_d        = 1'b0;
        if (flush) begin
            for (int i = 0; i < ROB_DEPTH; i++) begin
                valid_d[i] = 1'b0;
                done_d[i]  = 1'b0;
            end
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (wb_valid) begin
                if (wb_hit) begin
                    done_d[wb_tag] = 1'b1;
                    data_d[wb_tag] = wb_data;
                end else begin
                    stray_d = 1'b1;
                end
            end
            if (alloc_fire) begin
                valid_d[tail_q] = 1'b1;
                done_d[tail_q]  = 1'b0;
                func_d[tail_q]  = alloc_func;
                rd_d[tail_q]    = alloc_rd;
                tail_d          = tail_q + TAG_W'(1);
            end
            if (commit_fire) begin
                commit_valid_d  = 1'b1;
                commit_we_d     = (func_q[head_q][3:2] == 2'b00);
                commit_rd_d     = rd_q[head_q];
                commit_data_d   = data_q[head_q];
                commit_tag_d    = head_q;
                valid_d[head_q] = 1'b0;
                done_d[head_q]  = 1'b0;
                head_d          = head_q + TAG_W'(1);
            end
            count_d = count_q + CNT_W'(alloc_fire) - CNT_W'(commit_fire);
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < ROB_DEPTH; i++) begin
                valid_q[i] <= 1'b0;
                done_q[i]  <= 1'b0;
                func_q[i]  <= '0;
                rd_q[i]    <= '0;
                data_q[i]  <= '0;
            end
            head_q         <= '0;
            tail_q         <= '0;
            count_q        <= '0;
            commit_valid_q <= 1'b0;
            commit_we_q    <= 1'b0;
            commit_rd_q    <= '0;
            commit_data_q  <= '0;
            commit_tag_q   <= '0;
            stray_q        <= 1'b0;
        end else begin
            valid_q        <= valid_d;
            done_q         <= done_d;
            func_q         <= func_d;
            rd_q           <= rd_d;
            data_q         <= data_d;
            head_q         <= head_d;
            tail_q         <= tail_d;
            count_q        <= count_d;
            commit_valid_q <= commit_valid_d;
            commit_we_q    <= commit_we_d;
            commit_rd_q    <= commit_rd_d;
            commit_data_q  <= commit_data_d;
            commit_tag_q   <= commit_tag_d;
            stray_q        <= stray_d;
        end
    end

endmodule

// File: tb/tb_rob_commit.sv
// Directed bench for rob_commit: one task per scenario with inline checks.
module tb_rob_commit;

    logic        clk1;
    logic        rst_n;
    logic        alloc_valid;
    logic [3:0]  alloc_func;
    logic [3:0]  alloc_rd;
    logic        alloc_ready;
    logic [2:0]  alloc_tag;
    logic        wb_valid;
    logic [2:0]  wb_tag;
    logic [15:0] wb_data;
    logic        flush;
    logic        commit_valid;
    logic        commit_we;
    logic [3:0]  commit_rd;
    logic [15:0] commit_data;
    logic [2:0]  commit_tag;
    logic [2:0]  head_p;
    logic [2:0]  tail_p;
    logic [3:0]  count;
    logic        full;
    logic        empty;
    logic        stray_wb;

    int vectors;
    int miscompares;

    rob_commit dut (
        .clk1(clk1), .rst_n(rst_n),
        .alloc_valid(alloc_valid), .alloc_func(alloc_func), .alloc_rd(alloc_rd),
        .alloc_ready(alloc_ready), .alloc_tag(alloc_tag),
        .wb_valid(wb_valid), .wb_tag(wb_tag), .wb_data(wb_data),
        .flush(flush),
        .commit_valid(commit_valid), .commit_we(commit_we), .commit_rd(commit_rd),
        .commit_data(commit_data), .commit_tag(commit_tag),
        .head_p(head_p), .tail_p(tail_p), .count(count),
        .full(full), .empty(empty), .stray_wb(stray_wb)
    );

    // Clock
    initial clk1 = 1'b0;
    always #5 clk1 = ~clk1;

    // Advance one edge and settle 1 time unit past it.
    task automatic tick();
        @(posedge clk1);
        #1;
    endtask

    task automatic idle_inputs();
        alloc_valid = 1'b0;
        alloc_func  = 4'h0;
        alloc_rd    = 4'h0;
        wb_valid    = 1'b0;
        wb_tag      = 3'd0;
        wb_data     = 16'h0;
        flush       = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        vectors++; if (count !== 4'd0) begin miscompares++; $display("FAIL reset_count got %0d exp 0", count); end
        vectors++; if (empty !== 1'b1 || full !== 1'b0 || alloc_ready !== 1'b1) begin miscompares++; $display("FAIL reset_flags got empty=%b full=%b ready=%b exp 1 0 1", empty, full, alloc_ready); end
        vectors++; if (head_p !== 3'd0 || tail_p !== 3'd0) begin miscompares++; $display("FAIL reset_ptrs got head=%0d tail=%0d exp 0 0", head_p, tail_p); end
        vectors++; if ({commit_valid, commit_we, commit_rd, commit_data, commit_tag, stray_wb} !== 26'd0) begin miscompares++; $display("FAIL reset_commit_regs got v=%b we=%b rd=%h d=%h t=%h s=%b exp all 0", commit_valid, commit_we, commit_rd, commit_data, commit_tag, stray_wb); end
    endtask

    task automatic test_single_commit();
        do_reset();
        alloc_valid = 1'b1; alloc_func = 4'b0000; alloc_rd = 4'd3;
        #1;
        vectors++; if (alloc_tag !== 3'd0) begin miscompares++; $display("FAIL single_alloc_tag got %0d exp 0", alloc_tag); end
        tick();
        alloc_valid = 1'b0;
        vectors++; if (count !== 4'd1 || tail_p !== 3'd1) begin miscompares++; $display("FAIL single_after_alloc got count=%0d tail=%0d exp 1 1", count, tail_p); end
        wb_valid = 1'b1; wb_tag = 3'd0; wb_data = 16'h00AA;
        tick();
        wb_valid = 1'b0;
        vectors++; if (commit_valid !== 1'b0) begin miscompares++; $display("FAIL single_wb_same_edge got commit_valid=%b exp 0", commit_valid); end
        tick();
        vectors++; if (commit_valid !== 1'b1 || commit_we !== 1'b1 || commit_rd !== 4'd3 || commit_data !== 16'h00AA || commit_tag !== 3'd0) begin
            miscompares++; $display("FAIL single_commit got v=%b we=%b rd=%0d d=%h t=%0d exp 1 1 3 00aa 0", commit_valid, commit_we, commit_rd, commit_data, commit_tag);
        end
        vectors++; if (count !== 4'd0 || empty !== 1'b1 || head_p !== 3'd1) begin miscompares++; $display("FAIL single_drained got count=%0d empty=%b head=%0d exp 0 1 1", count, empty, head_p); end
        tick();
        vectors++; if (commit_valid !== 1'b0 || commit_data !== 16'h00AA) begin miscompares++; $display("FAIL single_pulse_hold got v=%b d=%h exp 0 00aa", commit_valid, commit_data); end
    endtask

    task automatic test_in_order();
        logic [15:0] exp_data [3];
        exp_data[0] = 16'h0C0C; exp_data[1] = 16'h1111; exp_data[2] = 16'h2222;
        do_reset();
        for (int i = 0; i < 3; i++) begin
            alloc_valid = 1'b1; alloc_func = 4'b0001; alloc_rd = 4'(i + 1);
            #1;
            vectors++; if (alloc_tag !== 3'(i)) begin miscompares++; $display("FAIL order_alloc_tag got %0d exp %0d", alloc_tag, i); end
            tick();
        end
        alloc_valid = 1'b0;
        for (int i = 2; i >= 0; i--) begin
            wb_valid = 1'b1; wb_tag = 3'(i); wb_data = exp_data[i];
            tick();
            vectors++; if (commit_valid !== 1'b0) begin miscompares++; $display("FAIL order_early_commit got v=%b exp 0 after wb tag %0d", commit_valid, i); end
        end
        wb_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            vectors++; if (commit_valid !== 1'b1 || commit_tag !== 3'(i) || commit_data !== exp_data[i] || commit_rd !== 4'(i + 1)) begin
                miscompares++; $display("FAIL order_commit got v=%b t=%0d d=%h rd=%0d exp 1 %0d %h %0d", commit_valid, commit_tag, commit_data, commit_rd, i, exp_data[i], i + 1);
            end
        end
        tick();
        vectors++; if (commit_valid !== 1'b0 || empty !== 1'b1) begin miscompares++; $display("FAIL order_end got v=%b empty=%b exp 0 1", commit_valid, empty); end
    endtask

    task automatic test_full();
        do_reset();
        alloc_valid = 1'b1; alloc_func = 4'b0000; alloc_rd = 4'd9;
        for (int i = 0; i < 8; i++) tick();
        vectors++; if (full !== 1'b1 || alloc_ready !== 1'b0 || count !== 4'd8 || tail_p !== 3'd0) begin
            miscompares++; $display("FAIL full_after8 got full=%b ready=%b count=%0d tail=%0d exp 1 0 8 0", full, alloc_ready, count, tail_p);
        end
        tick();
        vectors++; if (count !== 4'd8 || tail_p !== 3'd0) begin miscompares++; $display("FAIL full_9th_ignored got count=%0d tail=%0d exp 8 0", count, tail_p); end
        wb_valid = 1'b1; wb_tag = 3'd0; wb_data = 16'hF00D;
        tick();
        wb_valid = 1'b0;
        vectors++; if (alloc_ready !== 1'b0) begin miscompares++; $display("FAIL full_ready_before_commit got %b exp 0", alloc_ready); end
        tick();
        vectors++; if (commit_valid !== 1'b1 || count !== 4'd7 || tail_p !== 3'd0 || head_p !== 3'd1) begin
            miscompares++; $display("FAIL full_commit_refuses got v=%b count=%0d tail=%0d head=%0d exp 1 7 0 1", commit_valid, count, tail_p, head_p);
        end
        vectors++; if (alloc_ready !== 1'b1 || alloc_tag !== 3'd0) begin miscompares++; $display("FAIL full_wrap_tag got ready=%b tag=%0d exp 1 0", alloc_ready, alloc_tag); end
        tick();
        alloc_valid = 1'b0;
        vectors++; if (count !== 4'd8 || tail_p !== 3'd1 || full !== 1'b1) begin miscompares++; $display("FAIL full_wrap_alloc got count=%0d tail=%0d full=%b exp 8 1 1", count, tail_p, full); end
    endtask

    task automatic test_branch_stray();
        do_reset();
        alloc_valid = 1'b1; alloc_func = 4'b0100; alloc_rd = 4'd5;
        tick();
        alloc_valid = 1'b0;
        wb_valid = 1'b1; wb_tag = 3'd0; wb_data = 16'h1234;
        tick();
        wb_valid = 1'b0;
        tick();
        vectors++; if (commit_valid !== 1'b1 || commit_we !== 1'b0 || commit_rd !== 4'd5 || commit_data !== 16'h1234) begin
            miscompares++; $display("FAIL branch_commit got v=%b we=%b rd=%0d d=%h exp 1 0 5 1234", commit_valid, commit_we, commit_rd, commit_data);
        end
        // Writeback to an entry that has already retired (now empty)
        wb_valid = 1'b1; wb_tag = 3'd0; wb_data = 16'hDEAD;
        tick();
        wb_valid = 1'b0;
        vectors++; if (stray_wb !== 1'b1 || count !== 4'd0 || commit_valid !== 1'b0) begin miscompares++; $display("FAIL stray_empty got stray=%b count=%0d v=%b exp 1 0 0", stray_wb, count, commit_valid); end
        tick();
        vectors++; if (stray_wb !== 1'b0) begin miscompares++; $display("FAIL stray_pulse got %b exp 0", stray_wb); end
        // Tags 1 and 2; complete the younger one twice
        alloc_valid = 1'b1; alloc_func = 4'b0010; alloc_rd = 4'd7;
        tick();
        alloc_rd = 4'd8;
        tick();
        alloc_valid = 1'b0;
        wb_valid = 1'b1; wb_tag = 3'd2; wb_data = 16'h3333;
        tick();
        vectors++; if (stray_wb !== 1'b0) begin miscompares++; $display("FAIL stray_first_wb got %b exp 0", stray_wb); end
        wb_data = 16'h0BAD;
        tick();
        wb_valid = 1'b0;
        vectors++; if (stray_wb !== 1'b1 || commit_valid !== 1'b0) begin miscompares++; $display("FAIL stray_done got stray=%b v=%b exp 1 0", stray_wb, commit_valid); end
        // Same-cycle alloc and writeback to the tail index is stray
        alloc_valid = 1'b1; alloc_func = 4'b0000; alloc_rd = 4'd4;
        wb_valid = 1'b1; wb_tag = 3'd3; wb_data = 16'h4444;
        tick();
        alloc_valid = 1'b0;
        wb_tag = 3'd1; wb_data = 16'h2222;
        tick();
        wb_valid = 1'b0;
        vectors++; if (stray_wb !== 1'b0 || count !== 4'd3) begin miscompares++; $display("FAIL stray_tail_then_head got stray=%b count=%0d exp 0 3", stray_wb, count); end
        tick();
        vectors++; if (commit_valid !== 1'b1 || commit_tag !== 3'd1 || commit_data !== 16'h2222 || commit_we !== 1'b1) begin
            miscompares++; $display("FAIL stray_commit1 got v=%b t=%0d d=%h we=%b exp 1 1 2222 1", commit_valid, commit_tag, commit_data, commit_we);
        end
        tick();
        vectors++; if (commit_valid !== 1'b1 || commit_tag !== 3'd2 || commit_data !== 16'h3333) begin
            miscompares++; $display("FAIL stray_unchanged got v=%b t=%0d d=%h exp 1 2 3333", commit_valid, commit_tag, commit_data);
        end
        tick();
        vectors++; if (commit_valid !== 1'b0 || count !== 4'd1) begin miscompares++; $display("FAIL stray_tail_not_done got v=%b count=%0d exp 0 1", commit_valid, count); end
    endtask

    task automatic test_flush();
        do_reset();
        alloc_valid = 1'b1; alloc_func = 4'b0000; alloc_rd = 4'd2;
        for (int i = 0; i < 5; i++) tick();
        alloc_valid = 1'b0;
        wb_valid = 1'b1; wb_tag = 3'd1; wb_data = 16'h0101;
        tick();
        wb_tag = 3'd3; wb_data = 16'h0303;
        tick();
        wb_valid = 1'b0;
        vectors++; if (count !== 4'd5 || commit_valid !== 1'b0) begin miscompares++; $display("FAIL flush_setup got count=%0d v=%b exp 5 0", count, commit_valid); end
        flush = 1'b1; alloc_valid = 1'b1; wb_valid = 1'b1; wb_tag = 3'd0; wb_data = 16'h0000;
        tick();
        flush = 1'b0; alloc_valid = 1'b0; wb_valid = 1'b0;
        vectors++; if (count !== 4'd0 || head_p !== 3'd0 || tail_p !== 3'd0 || empty !== 1'b1 || commit_valid !== 1'b0 || stray_wb !== 1'b0) begin
            miscompares++; $display("FAIL flush_clear got count=%0d head=%0d tail=%0d empty=%b v=%b stray=%b exp 0 0 0 1 0 0", count, head_p, tail_p, empty, commit_valid, stray_wb);
        end
        vectors++; if (alloc_tag !== 3'd0) begin miscompares++; $display("FAIL flush_next_tag got %0d exp 0", alloc_tag); end
        alloc_valid = 1'b1;
        tick();
        alloc_valid = 1'b0;
        // Old done bit at index 1 must be gone: allocate tag 1 and check it waits.
        alloc_valid = 1'b1;
        tick();
        alloc_valid = 1'b0;
        wb_valid = 1'b1; wb_tag = 3'd0; wb_data = 16'h0A0A;
        tick();
        wb_valid = 1'b0;
        tick();
        tick();
        vectors++; if (count !== 4'd1 || head_p !== 3'd1 || commit_valid !== 1'b0) begin miscompares++; $display("FAIL flush_done_cleared got count=%0d head=%0d v=%b exp 1 1 0", count, head_p, commit_valid); end
    endtask

    task automatic test_async_reset();
        do_reset();
        alloc_valid = 1'b1; alloc_func = 4'b0000; alloc_rd = 4'd6;
        tick();
        tick();
        alloc_valid = 1'b0;
        wb_valid = 1'b1; wb_tag = 3'd0; wb_data = 16'h5A5A;
        tick();
        wb_tag = 3'd1; wb_data = 16'hA5A5;
        tick();
        wb_valid = 1'b0;
        vectors++; if (commit_valid !== 1'b1 || commit_data !== 16'h5A5A) begin miscompares++; $display("FAIL async_pre got v=%b d=%h exp 1 5a5a", commit_valid, commit_data); end
        #2;
        rst_n = 1'b0;
        #1;
        vectors++; if (commit_valid !== 1'b0 || commit_data !== 16'h0 || commit_rd !== 4'd0 || count !== 4'd0 || head_p !== 3'd0 || tail_p !== 3'd0) begin
            miscompares++; $display("FAIL async_reset got v=%b d=%h rd=%0d count=%0d head=%0d tail=%0d exp all 0", commit_valid, commit_data, commit_rd, count, head_p, tail_p);
        end
        tick();
        rst_n = 1'b1;
        alloc_valid = 1'b1; alloc_func = 4'b0000; alloc_rd = 4'd3;
        #1;
        vectors++; if (alloc_tag !== 3'd0) begin miscompares++; $display("FAIL async_after_tag got %0d exp 0", alloc_tag); end
        tick();
        alloc_valid = 1'b0;
        wb_valid = 1'b1; wb_tag = 3'd0; wb_data = 16'h00AA;
        tick();
        wb_valid = 1'b0;
        tick();
        vectors++; if (commit_valid !== 1'b1 || commit_we !== 1'b1 || commit_rd !== 4'd3 || commit_data !== 16'h00AA || commit_tag !== 3'd0 || count !== 4'd0) begin
            miscompares++; $display("FAIL async_after_commit got v=%b we=%b rd=%0d d=%h t=%0d count=%0d exp 1 1 3 00aa 0 0", commit_valid, commit_we, commit_rd, commit_data, commit_tag, count);
        end
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        idle_inputs();
        rst_n = 1'b0;
        test_reset();
        test_single_commit();
        test_in_order();
        test_full();
        test_branch_stray();
        test_flush();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
